rf_scoreboard: RTL and testbench

- Parametrised successor to the processor's register file.
- Clocked synchronous write, N combinational read ports with write-to-read bypass, and register 0 hardwired to zero.
- Adds a per-register pending scoreboard so the decode stage can detect RAW/WAW hazards.
- Sits between decode (read/issue side) and writeback (write side) of the pipeline.

---
 rtl/rf_pkg.sv | 18 +
 rtl/rf_read_port.sv | 42 ++++
 rtl/rf_scoreboard.sv | 113 +++++++++++
 tb/tb_rf_scoreboard.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the register file with scoreboard.
// Imported by the read port and the top.
package rf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    // LSB of port k in a packed bus whose fields are w bits wide.
    function automatic int unsigned port_lsb(
        input int unsigned k,
        input int unsigned w
    );
        return k * w;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: array mux, write bypass,
// zero-register override and busy masking.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]      ra,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      wa,
    input  logic [DATA_W-1:0]      wd,
    input  logic [DATA_W-1:0]      mem [2**ADDR_W],
    input  logic [2**ADDR_W-1:0]   pend,
    output logic [DATA_W-1:0]      rd,
    output logic                   busy
);

    logic addr_hit;
    logic fwd;
    logic zero_ra;
    logic zero_wa;

    assign addr_hit = (BYPASS != 0) && we && (wa == ra);
    assign zero_wa  = (ZERO_REG != 0) && (wa == '0);
    assign zero_ra  = (ZERO_REG != 0) && (ra == '0);
    assign fwd      = addr_hit && !zero_wa;

    always_comb begin
        rd = mem[ra];
        if (fwd)
            rd = wd;
        if (zero_ra)
            rd = '0;
    end

    // A same-cycle writeback retires the producer, so the source is ready.
    assign busy = pend[ra] && !addr_hit;

endmodule

// File: rtl/rf_scoreboard.sv
// Register file with N bypassing read ports and a per-register
// pending scoreboard for RAW/WAW hazard detection at decode.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wa,
    input  logic [DATA_W-1:0]       wd,
    input  logic [NREAD*ADDR_W-1:0] ra,
    output logic [NREAD*DATA_W-1:0] rd,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    issue_en,
    input  logic [ADDR_W-1:0]       issue_rd,
    output logic                    issue_busy,
    input  logic                    flush,
    output logic [ADDR_W:0]         pend_cnt
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              issue_ok;
    logic              wr_ok;
    logic              inc;
    logic              dec;

    assign wr_ok    = we && !((ZERO_REG != 0) && (wa == '0));
    assign issue_ok = issue_en
                   && !((ZERO_REG != 0) && (issue_rd == '0));

    for (genvar k = 0; k < NREAD; k++) begin : g_rp
        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rp (
            .ra   (ra[port_lsb(k, ADDR_W) +: ADDR_W]),
            .we   (we),
            .wa   (wa),
            .wd   (wd),
            .mem  (mem),
            .pend (pend),
            .rd   (rd[port_lsb(k, DATA_W) +: DATA_W]),
            .busy (rd_busy[k])
        );
    end

    assign issue_busy = issue_en && pend[issue_rd]
                     && !(we && (wa == issue_rd));

    // A new issue outranks flush and writeback: it is a fresh producer.
    always_comb begin
        pend_nxt = pend;
        for (int r = 0; r < DEPTH; r++) begin
            if (flush)
                pend_nxt[r] = 1'b0;
            if (we && (wa == ADDR_W'(r)))
                pend_nxt[r] = 1'b0;
            if (issue_ok && (issue_rd == ADDR_W'(r)))
                pend_nxt[r] = 1'b1;
        end
    end

    // Writeback and issue to the same pending register cancel out.
    assign inc = issue_ok && !pend[issue_rd];
    assign dec = we && pend[wa]
              && !(issue_ok && (issue_rd == wa));

    always_comb begin
        cnt_nxt = pend_cnt;
        if (flush) begin
            cnt_nxt = issue_ok ? ONE : '0;
        end else begin
            if (inc)
                cnt_nxt = cnt_nxt + ONE;
            if (dec)
                cnt_nxt = cnt_nxt - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wa] <= wd;
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Randomized and directed bench for rf_scoreboard, checked against
// an array-level reference model; drives BYPASS=1 and BYPASS=0 copies.
module tb_rf_scoreboard;
    import rf_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    reg_addr_t   wa;
    logic [31:0] wd;
    logic [9:0]  ra;
    logic        issue_en;
    reg_addr_t   issue_rd;
    logic        flush;

    logic [63:0] rd_b, rd_n;
    logic [1:0]  busy_b, busy_n;
    logic        ib_b, ib_n;
    logic [5:0]  cnt_b, cnt_n;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_mem [32];
    bit          m_pend [32];

    always #5 clk = ~clk;

    rf_scoreboard #(.BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra(ra), .rd(rd_b), .rd_busy(busy_b),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .issue_busy(ib_b), .flush(flush), .pend_cnt(cnt_b)
    );

    rf_scoreboard #(.BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra(ra), .rd(rd_n), .rd_busy(busy_n),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .issue_busy(ib_n), .flush(flush), .pend_cnt(cnt_n)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input bit byp,
                                           input reg_addr_t a);
        if (a == 0)
            return 32'd0;
        if (byp && we && wa == a)
            return wd;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input bit byp,
                                      input reg_addr_t a);
        return m_pend[a] && !(byp && we && wa == a);
    endfunction

    function automatic logic [5:0] exp_cnt();
        int n = 0;
        for (int r = 0; r < 32; r++)
            n += int'(m_pend[r]);
        return 6'(n);
    endfunction

    task automatic sample();
        reg_addr_t a;
        logic      eib;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            a = ra[k*5 +: 5];
            chk($sformatf("rd_b%0d", k), rd_b[k*32 +: 32], exp_rd(1, a));
            chk($sformatf("rd_n%0d", k), rd_n[k*32 +: 32], exp_rd(0, a));
            chk($sformatf("busy_b%0d", k), busy_b[k], exp_busy(1, a));
            chk($sformatf("busy_n%0d", k), busy_n[k], exp_busy(0, a));
        end
        eib = issue_en && m_pend[issue_rd] && !(we && wa == issue_rd);
        chk("issue_busy_b", ib_b, eib);
        chk("issue_busy_n", ib_n, eib);
        chk("cnt_b", cnt_b, exp_cnt());
        chk("cnt_n", cnt_n, exp_cnt());
    endtask

    task automatic advance();
        bit np [32];
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[r]  = '0;
                m_pend[r] = 1'b0;
            end
        end else begin
            for (int r = 0; r < 32; r++) begin
                np[r] = m_pend[r];
                if (flush) np[r] = 1'b0;
                if (we && wa == r) np[r] = 1'b0;
                if (issue_en && issue_rd == r && r != 0) np[r] = 1'b1;
            end
            m_pend = np;
            if (we && wa != 0)
                m_mem[wa] = wd;
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; we = 0; wa = '0; wd = '0; ra = '0;
        issue_en = 0; issue_rd = '0; flush = 0;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    function automatic reg_addr_t rnd_a();
        if ($urandom_range(0, 3) == 0)
            return reg_addr_t'($urandom_range(0, 31));
        return reg_addr_t'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_mem[r]  = '0;
            m_pend[r] = 1'b0;
        end
        idle();
        rst = 1;
        advance();

        // preload, then reset with a write that must be dropped
        idle(); we = 1; wa = 3; wd = 32'hA5; cyc();
        idle(); we = 1; wa = 5; wd = 32'h11; issue_en = 1; issue_rd = 6; cyc();
        idle(); rst = 1; we = 1; wa = 3; wd = 32'h55; issue_en = 1;
        issue_rd = 8; flush = 0; cyc();
        idle(); ra = {5'd5, 5'd3};
        sample();
        chk("rst_rd3", rd_b[31:0], 32'h0);
        chk("rst_rd5", rd_b[63:32], 32'h0);
        chk("rst_cnt", cnt_b, 6'd0);
        advance();

        // write with same-cycle bypass
        idle(); we = 1; wa = 5; wd = 32'hDEADBEEF; ra = {5'd0, 5'd5};
        sample();
        chk("byp_rd", rd_b[31:0], 32'hDEADBEEF);
        chk("nobyp_rd", rd_n[31:0], 32'h0);
        advance();
        idle(); ra = {5'd0, 5'd5};
        sample();
        chk("wr_rd_b", rd_b[31:0], 32'hDEADBEEF);
        chk("wr_rd_n", rd_n[31:0], 32'hDEADBEEF);
        advance();

        // zero register ignores writes and issues
        idle(); we = 1; wa = 0; wd = 32'h1234; issue_en = 1; issue_rd = 0;
        sample();
        chk("zero_rd", rd_b[31:0], 32'h0);
        chk("zero_busy", busy_b[0], 1'b0);
        advance();
        idle();
        sample();
        chk("zero_cnt", cnt_b, 6'd0);
        advance();

        // RAW on register 7
        idle(); issue_en = 1; issue_rd = 7; cyc();
        idle(); ra = {5'd7, 5'd0};
        sample();
        chk("raw_busy", busy_b[1], 1'b1);
        chk("raw_cnt", cnt_b, 6'd1);
        advance();
        idle(); we = 1; wa = 7; wd = 32'd9; ra = {5'd7, 5'd0};
        sample();
        chk("raw_wb_busy", busy_b[1], 1'b0);
        chk("raw_wb_rd", rd_b[63:32], 32'd9);
        chk("raw_wb_busy_n", busy_n[1], 1'b1);
        advance();
        idle();
        sample();
        chk("raw_cnt0", cnt_b, 6'd0);
        advance();

        // issue and writeback collide on pending register 4
        idle(); issue_en = 1; issue_rd = 4; cyc();
        idle(); issue_en = 1; issue_rd = 4; we = 1; wa = 4; wd = 32'h44;
        sample();
        chk("coll_ib", ib_b, 1'b0);
        advance();
        idle(); issue_en = 1; issue_rd = 4; ra = {5'd0, 5'd4};
        sample();
        chk("waw_ib", ib_b, 1'b1);
        chk("coll_cnt", cnt_b, 6'd1);
        advance();

        // flush with a coinciding issue
        idle(); flush = 1; cyc();
        idle(); we = 1; wa = 2; wd = 32'h22; issue_en = 1; issue_rd = 2; cyc();
        idle(); we = 1; wa = 3; wd = 32'h33; issue_en = 1; issue_rd = 3; cyc();
        idle(); we = 1; wa = 9; wd = 32'h99; issue_en = 1; issue_rd = 9; cyc();
        idle();
        sample();
        chk("fl_cnt3", cnt_b, 6'd3);
        advance();
        idle(); flush = 1; issue_en = 1; issue_rd = 11; cyc();
        idle(); ra = {5'd11, 5'd2};
        sample();
        chk("fl_cnt1", cnt_b, 6'd1);
        chk("fl_busy11", busy_b[1], 1'b1);
        chk("fl_busy2", busy_b[0], 1'b0);
        chk("fl_rd2", rd_b[31:0], 32'h22);
        advance();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            we       = $urandom_range(0, 1) == 1;
            wa       = rnd_a();
            wd       = $urandom;
            issue_en = $urandom_range(0, 2) != 0;
            issue_rd = rnd_a();
            ra       = {rnd_a(), rnd_a()};
            if ($urandom_range(0, 3) == 0)
                ra[9:5] = ra[4:0];
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
